// File: rtl/bram_dp_be_if.sv
// Port bundle for one side of the dual-port byte-enable RAM.
// The requester drives the access fields; the RAM returns read data and its valid pulse.
interface bram_dp_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NB         = 4
);
    logic                  en;
    logic [NB-1:0]         we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (output en, we, addr, wdata, input rdata, rvalid);
    modport slave  (input en, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/bram_dp_be.sv
// True dual-port block RAM with per-byte write enables, selectable same-port
// read-during-write behaviour and a 1- or 2-cycle registered read path.
// Across ports a read always sees the word as it was before this cycle's writes;
// on a write/write address clash port A owns every lane it enables.
module bram_dp_be #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0
) (
    input logic        clk,
    input logic        rst,       // asynchronous, active low
    bram_dp_be_if.slave a,
    bram_dp_be_if.slave b
);
    localparam int NB    = RAM_DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** RAM_ADDR_WIDTH;

    // Reject configurations the datapath cannot represent
    if (RAM_DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_width
        $error("bram_dp_be: RAM_DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_latency
        $error("bram_dp_be: READ_LATENCY must be 1 or 2");
    end
    if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_err_rdw
        $error("bram_dp_be: RDW_MODE must be 0, 1 or 2");
    end

    // Both ports flattened into index 0 (A) and 1 (B) so one generate body serves both
    logic                      en_w    [2];
    logic [NB-1:0]             wr_w    [2];
    logic [RAM_ADDR_WIDTH-1:0] addr_w  [2];
    logic [RAM_DATA_WIDTH-1:0] wdata_w [2];
    logic [RAM_DATA_WIDTH-1:0] rdata_w [2];
    logic                      rvalid_w[2];

    assign en_w[0]    = a.en;
    assign en_w[1]    = b.en;
    assign wr_w[0]    = a.en ? a.we : '0;   // byte enables only count when the port is enabled
    assign wr_w[1]    = b.en ? b.we : '0;
    assign addr_w[0]  = a.addr;
    assign addr_w[1]  = b.addr;
    assign wdata_w[0] = a.wdata;
    assign wdata_w[1] = b.wdata;
    assign a.rdata    = rdata_w[0];
    assign a.rvalid   = rvalid_w[0];
    assign b.rdata    = rdata_w[1];
    assign b.rvalid   = rvalid_w[1];

    // Storage array; contents survive reset
    logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes: B lanes first, A lanes last so A overrides B on a shared lane
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_w[1][i]) mem[addr_w[1]][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_w[1][i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_w[0][i]) mem[addr_w[0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_w[0][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [RAM_DATA_WIDTH-1:0] old_word;
        logic [RAM_DATA_WIDTH-1:0] merged_word;
        logic [RAM_DATA_WIDTH-1:0] read_word;
        logic                      accept;

        // Pick the word this access returns and whether it produces a result at all
        always_comb begin
            old_word    = mem[addr_w[gi]];
            merged_word = old_word;
            for (int i = 0; i < NB; i++) begin
                if (wr_w[gi][i]) merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_w[gi][i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            // The merge only ever uses this port's own bytes; the other port is read-first
            read_word = (RDW_MODE == 1) ? merged_word : old_word;
            // NO_CHANGE suppresses the result of any access that writes
            accept    = en_w[gi] && !((RDW_MODE == 2) && (|wr_w[gi]));
        end

        if (READ_LATENCY == 1) begin : g_lat1
            logic [RAM_DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                      rvalid_q, rvalid_d;

            // Output register: load on an accepted access, otherwise hold
            always_comb begin
                rdata_d  = accept ? read_word : rdata_q;
                rvalid_d = accept;
            end

            // Output register state
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rdata_w[gi]  = rdata_q;
            assign rvalid_w[gi] = rvalid_q;
        end else begin : g_lat2
            logic [RAM_DATA_WIDTH-1:0] s1_data_q, s1_data_d, rdata_q, rdata_d;
            logic                      s1_valid_q, s1_valid_d, rvalid_q, rvalid_d;

            // Two-stage read pipe: stage 1 captures, output stage loads only valid beats
            always_comb begin
                s1_data_d  = accept ? read_word : s1_data_q;
                s1_valid_d = accept;
                rdata_d    = s1_valid_q ? s1_data_q : rdata_q;
                rvalid_d   = s1_valid_q;
            end

            // Pipeline state; reset discards anything in flight
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_data_q  <= '0;
                    s1_valid_q <= 1'b0;
                    rdata_q    <= '0;
                    rvalid_q   <= 1'b0;
                end else begin
                    s1_data_q  <= s1_data_d;
                    s1_valid_q <= s1_valid_d;
                    rdata_q    <= rdata_d;
                    rvalid_q   <= rvalid_d;
                end
            end

            assign rdata_w[gi]  = rdata_q;
            assign rvalid_w[gi] = rvalid_q;
        end
    end
endmodule

// File: tb/tb_bram_dp_be.sv
// Bench for bram_dp_be: three instances share one stimulus stream.
//   inst 0: READ_LATENCY=1, READ_FIRST
//   inst 1: READ_LATENCY=2, WRITE_FIRST
//   inst 2: READ_LATENCY=1, NO_CHANGE
// Directed vectors first, then concurrent random traffic against a reference model.
module tb_bram_dp_be;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we, a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [31:0] a_rd [3];
    logic [31:0] b_rd [3];
    logic        a_rv [3];
    logic        b_rv [3];

    int n_cmp = 0;
    int n_mis = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT  = (gi == 1) ? 2 : 1;
        localparam int MODE = gi;
        bram_dp_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NB(4)) ia ();
        bram_dp_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NB(4)) ib ();
        assign ia.en    = a_en;
        assign ia.we    = a_we;
        assign ia.addr  = a_addr;
        assign ia.wdata = a_wdata;
        assign ib.en    = b_en;
        assign ib.we    = b_we;
        assign ib.addr  = b_addr;
        assign ib.wdata = b_wdata;
        assign a_rd[gi] = ia.rdata;
        assign a_rv[gi] = ia.rvalid;
        assign b_rd[gi] = ib.rdata;
        assign b_rv[gi] = ib.rvalid;
        bram_dp_be #(
            .RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(4), .BYTE_WIDTH(8),
            .READ_LATENCY(LAT), .RDW_MODE(MODE)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .a   (ia),
            .b   (ib)
        );
    end

    function automatic int lat(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] lanes);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (lanes[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Result snapshot of the latest directed transaction, taken at each instance's latency;
    // o*_v is rvalid in the other sampled cycle (must be low: one-cycle pulse)
    logic [31:0] ra_d [3];
    logic [31:0] rb_d [3];
    logic        ra_v [3];
    logic        rb_v [3];
    logic        oa_v [3];
    logic        ob_v [3];

    task automatic xact(input string tag,
                        input logic ae, input logic [3:0] awe, input logic [3:0] aad, input logic [31:0] awd,
                        input logic be, input logic [3:0] bwe, input logic [3:0] bad, input logic [31:0] bwd);
        a_en = ae; a_we = awe; a_addr = aad; a_wdata = awd;
        b_en = be; b_we = bwe; b_addr = bad; b_wdata = bwd;
        @(posedge clk); #1;
        a_en = 1'b0; a_we = '0; b_en = 1'b0; b_we = '0;
        for (int i = 0; i < 3; i++) begin
            if (lat(i) == 1) begin
                ra_d[i] = a_rd[i]; ra_v[i] = a_rv[i]; rb_d[i] = b_rd[i]; rb_v[i] = b_rv[i];
            end else begin
                oa_v[i] = a_rv[i]; ob_v[i] = b_rv[i];
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (lat(i) == 2) begin
                ra_d[i] = a_rd[i]; ra_v[i] = a_rv[i]; rb_d[i] = b_rd[i]; rb_v[i] = b_rv[i];
            end else begin
                oa_v[i] = a_rv[i]; ob_v[i] = b_rv[i];
            end
        end
        $display("xact %-10s A en=%0d we=%h @%0d wd=%08h | B en=%0d we=%h @%0d wd=%08h",
                 tag, ae, awe, aad, awd, be, bwe, bad, bwd);
    endtask

    // Check one instance/port of the latest transaction; d is the held value when v=0
    task automatic exp_one(input string tag, input int i, input bit pb, input logic v, input logic [31:0] d);
        string t;
        t = $sformatf("%s i%0d %s", tag, i, pb ? "B" : "A");
        check({t, " rvalid"}, pb ? rb_v[i] : ra_v[i], v);
        check({t, " rdata"},  pb ? rb_d[i] : ra_d[i], d);
        if (v) check({t, " pulse"}, pb ? ob_v[i] : oa_v[i], 1'b0);
    endtask

    task automatic exp_all(input string tag, input bit pb, input logic [31:0] d);
        for (int i = 0; i < 3; i++) exp_one(tag, i, pb, 1'b1, d);
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s i%0d A rdata", tag, i), a_rd[i], 32'h0);
            check($sformatf("%s i%0d A rvalid", tag, i), a_rv[i], 1'b0);
            check($sformatf("%s i%0d B rdata", tag, i), b_rd[i], 32'h0);
            check($sformatf("%s i%0d B rvalid", tag, i), b_rv[i], 1'b0);
        end
    endtask

    // Reference model state for the random phase
    logic [31:0] model_mem [16];
    logic        hist_v [3][2][4];
    logic [31:0] hist_d [3][2][4];

    localparam int N_RAND = 2000;

    initial begin
        rst = 1'b0;
        a_en = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;

        // Basic write then read
        xact("wr3", 1, 4'hF, 3, 32'hDEADBEEF, 0, 4'h0, 0, 32'h0);
        exp_one("wr3", 2, 0, 1'b0, 32'h0);
        xact("rd3", 1, 4'h0, 3, 32'h0, 0, 4'h0, 0, 32'h0);
        exp_all("rd3", 0, 32'hDEADBEEF);

        // Byte-enable merge and same-port RDW on a partial write
        xact("wr5", 1, 4'hF, 5, 32'h11223344, 0, 4'h0, 0, 32'h0);
        exp_one("wr5", 1, 0, 1'b1, 32'h11223344);
        exp_one("wr5", 2, 0, 1'b0, 32'hDEADBEEF);
        xact("merge5", 1, 4'b0101, 5, 32'hAABBCCDD, 0, 4'h0, 0, 32'h0);
        exp_one("merge5", 0, 0, 1'b1, 32'h11223344);
        exp_one("merge5", 1, 0, 1'b1, 32'h11BB33DD);
        exp_one("merge5", 2, 0, 1'b0, 32'hDEADBEEF);
        xact("rd5", 1, 4'h0, 5, 32'h0, 0, 4'h0, 0, 32'h0);
        exp_all("rd5", 0, 32'h11BB33DD);

        // Same-port read-during-write on a full word
        xact("wr7", 1, 4'hF, 7, 32'h1, 0, 4'h0, 0, 32'h0);
        xact("rdw7", 1, 4'hF, 7, 32'h2, 0, 4'h0, 0, 32'h0);
        exp_one("rdw7", 0, 0, 1'b1, 32'h1);
        exp_one("rdw7", 1, 0, 1'b1, 32'h2);
        exp_one("rdw7", 2, 0, 1'b0, 32'h11BB33DD);
        xact("rd7", 1, 4'h0, 7, 32'h0, 0, 4'h0, 0, 32'h0);
        exp_all("rd7", 0, 32'h2);

        // Cross-port read-first
        xact("wr9", 1, 4'hF, 9, 32'h4, 0, 4'h0, 0, 32'h0);
        xact("xrd9", 1, 4'hF, 9, 32'h5, 1, 4'h0, 9, 32'h0);
        exp_all("xrd9", 1, 32'h4);
        exp_one("xrd9", 0, 0, 1'b1, 32'h4);
        exp_one("xrd9", 1, 0, 1'b1, 32'h5);
        exp_one("xrd9", 2, 0, 1'b0, 32'h2);

        // Write/write collision: A owns lanes 0-1, B alone writes lanes 2-3
        xact("ww9", 1, 4'b0011, 9, 32'hAAAAAAAA, 1, 4'hF, 9, 32'hBBBBBBBB);
        exp_one("ww9", 0, 1, 1'b1, 32'h5);
        exp_one("ww9", 1, 1, 1'b1, 32'hBBBBBBBB);
        exp_one("ww9", 1, 0, 1'b1, 32'h0000AAAA);
        exp_one("ww9", 2, 1, 1'b0, 32'h4);
        xact("rdb9", 0, 4'h0, 0, 32'h0, 1, 4'h0, 9, 32'h0);
        exp_all("rdb9", 1, 32'hBBBBAAAA);

        // Disabled port: no write, no result
        xact("dis9", 0, 4'hF, 9, 32'h12345678, 0, 4'hF, 9, 32'h87654321);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dis9 i%0d A rvalid", i), ra_v[i], 1'b0);
            check($sformatf("dis9 i%0d B rvalid", i), rb_v[i], 1'b0);
        end
        xact("rda9", 1, 4'h0, 9, 32'h0, 0, 4'h0, 0, 32'h0);
        exp_all("rda9", 0, 32'hBBBBAAAA);

        // Both ports reading different words in the same cycle
        xact("dual", 1, 4'h0, 3, 32'h0, 1, 4'h0, 7, 32'h0);
        exp_all("dual", 0, 32'hDEADBEEF);
        exp_all("dual", 1, 32'h2);

        // Reset in the middle of in-flight reads
        a_en = 1'b1; a_we = '0; a_addr = 3; b_en = 1'b1; b_we = '0; b_addr = 5;
        @(posedge clk); #1;
        a_en = 1'b0; b_en = 1'b0;
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("post_rst c%0d i%0d A rvalid", c, i), a_rv[i], 1'b0);
                check($sformatf("post_rst c%0d i%0d B rvalid", c, i), b_rv[i], 1'b0);
            end
        end
        xact("rd_after", 1, 4'h0, 3, 32'h0, 1, 4'h0, 5, 32'h0);
        exp_all("rd_after", 0, 32'hDEADBEEF);
        exp_all("rd_after", 1, 32'h11BB33DD);

        // Random phase: known contents first, then concurrent traffic
        for (int ad = 0; ad < 16; ad++) begin
            model_mem[ad] = $urandom;
            xact("fill", 1, 4'hF, ad[3:0], model_mem[ad], 0, 4'h0, 0, 32'h0);
        end
        for (int c = 0; c < N_RAND + 2; c++) begin
            logic        en_p [2];
            logic [3:0]  wr_p [2];
            logic [3:0]  ad_p [2];
            logic [31:0] wd_p [2];
            logic [31:0] old_w, mrg_w;
            if (c < N_RAND) begin
                a_en = ($urandom_range(0, 9) < 7);
                b_en = ($urandom_range(0, 9) < 7);
                a_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
                b_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
                a_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                b_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                a_wdata = $urandom;
                b_wdata = $urandom;
            end else begin
                a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
            end
            en_p[0] = a_en; wr_p[0] = a_en ? a_we : 4'h0; ad_p[0] = a_addr; wd_p[0] = a_wdata;
            en_p[1] = b_en; wr_p[1] = b_en ? b_we : 4'h0; ad_p[1] = b_addr; wd_p[1] = b_wdata;
            for (int p = 0; p < 2; p++) begin
                old_w = model_mem[ad_p[p]];
                mrg_w = merge(old_w, wd_p[p], wr_p[p]);
                for (int i = 0; i < 3; i++) begin
                    if (en_p[p] && !(i == 2 && wr_p[p] != 4'h0)) begin
                        hist_v[i][p][c % 4] = 1'b1;
                        hist_d[i][p][c % 4] = (i == 1) ? mrg_w : old_w;
                    end else begin
                        hist_v[i][p][c % 4] = 1'b0;
                        hist_d[i][p][c % 4] = 32'h0;
                    end
                end
            end
            model_mem[ad_p[1]] = merge(model_mem[ad_p[1]], wd_p[1], wr_p[1]);
            model_mem[ad_p[0]] = merge(model_mem[ad_p[0]], wd_p[0], wr_p[0]);
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                int k;
                k = c - lat(i) + 1;
                if (k >= 0) begin
                    check($sformatf("rnd c%0d i%0d A rvalid", c, i), a_rv[i], hist_v[i][0][k % 4]);
                    if (hist_v[i][0][k % 4]) check($sformatf("rnd c%0d i%0d A rdata", c, i), a_rd[i], hist_d[i][0][k % 4]);
                    check($sformatf("rnd c%0d i%0d B rvalid", c, i), b_rv[i], hist_v[i][1][k % 4]);
                    if (hist_v[i][1][k % 4]) check($sformatf("rnd c%0d i%0d B rdata", c, i), b_rd[i], hist_d[i][1][k % 4]);
                end
            end
            $display("rand c=%0d A en=%0d we=%h @%0d | B en=%0d we=%h @%0d",
                     c, en_p[0], wr_p[0], ad_p[0], en_p[1], wr_p[1], ad_p[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
